// File: rtl/mips150_wb_pkg.sv
// mips150_wb_pkg: shared definitions for the MIPS150 writeback stage.
//   - Load-type encodings carried down the pipe on m_load_type.
//   - Default datapath / register-address widths.
package mips150_wb_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  typedef logic [2:0] load_type_t;

  localparam load_type_t LT_W  = 3'd0;
  localparam load_type_t LT_B  = 3'd1;
  localparam load_type_t LT_BU = 3'd2;
  localparam load_type_t LT_H  = 3'd3;
  localparam load_type_t LT_HU = 3'd4;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational big-endian load alignment and extension.
// Ports:
//   load_type  in  3   load kind (mips150_wb_pkg LT_* constants)
//   addr       in  2   byte offset of the effective address
//   rdata      in  32  raw data-memory word
//   data       out 32  aligned, sign/zero-extended load value
//   misalign   out 1   offset illegal for this load kind (ungated by valid)
// Reserved load_type codes pass the full word and never flag misalignment.
module load_align
  import mips150_wb_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        misalign
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    // Byte 0 is the most significant byte (big-endian).
    case (addr)
      2'd0:    byte_s = $signed(rdata[31:24]);
      2'd1:    byte_s = $signed(rdata[23:16]);
      2'd2:    byte_s = $signed(rdata[15:8]);
      default: byte_s = $signed(rdata[7:0]);
    endcase
    half_s = addr[1] ? $signed(rdata[15:0]) : $signed(rdata[31:16]);

    data     = rdata;
    misalign = 1'b0;
    case (load_type)
      LT_B:  data = 32'(byte_s);
      LT_BU: data = {24'h00_0000, byte_s};
      LT_H: begin
        data     = 32'(half_s);
        misalign = addr[0];
      end
      LT_HU: begin
        data     = {16'h0000, half_s};
        misalign = addr[0];
      end
      LT_W:    misalign = |addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load alignment, register-file write
// port and write-to-read bypass for the MIPS150 CPU.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall, flush              hold / bubble the WB register (flush wins)
//   m_valid, m_reg_we, m_mem_to_reg, m_load_type, m_rd_addr, m_alu_result
//                             memory-stage results captured into WB
//   mem_rdata                 data-memory word for the load currently in WB
//   ra1, ra2, rf_rd1, rf_rd2  decode read addresses and raw RF read data
//   rf_we, rf_wa, rf_wd       register-file write port
//   rs_val, rt_val            bypassed decode operands
//   wb_valid, misalign_err    WB status
//   retire_count              retired-instruction counter
// Optional feature: define WB_RETIRE_CNT_EN to build the retire counter;
// otherwise retire_count is tied to zero.
module wb_stage
  import mips150_wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          m_valid,
  input  logic          m_reg_we,
  input  logic          m_mem_to_reg,
  input  logic [2:0]    m_load_type,
  input  logic [AW-1:0] m_rd_addr,
  input  logic [DW-1:0] m_alu_result,
  input  logic [DW-1:0] mem_rdata,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [DW-1:0] rf_rd1,
  input  logic [DW-1:0] rf_rd2,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [DW-1:0] rs_val,
  output logic [DW-1:0] rt_val,
  output logic          wb_valid,
  output logic          misalign_err,
  output logic [31:0]   retire_count
);

  logic          vld_p1_q,    vld_p1_d;
  logic          reg_we_p1_q, reg_we_p1_d;
  logic          m2r_p1_q,    m2r_p1_d;
  logic [2:0]    lt_p1_q,     lt_p1_d;
  logic [AW-1:0] rd_p1_q,     rd_p1_d;
  logic [DW-1:0] alu_p1_q,    alu_p1_d;

  logic [DW-1:0] load_data;
  logic          load_mis;

  // ---- MEM -> WB boundary ----
  always_comb begin
    vld_p1_d    = vld_p1_q;
    reg_we_p1_d = reg_we_p1_q;
    m2r_p1_d    = m2r_p1_q;
    lt_p1_d     = lt_p1_q;
    rd_p1_d     = rd_p1_q;
    alu_p1_d    = alu_p1_q;
    if (flush) begin
      vld_p1_d = 1'b0;
    end else if (!stall) begin
      vld_p1_d    = m_valid;
      reg_we_p1_d = m_reg_we;
      m2r_p1_d    = m_mem_to_reg;
      lt_p1_d     = m_load_type;
      rd_p1_d     = m_rd_addr;
      alu_p1_d    = m_alu_result;
    end
  end

  // Data fields are cleared too so rf_wa/rf_wd come out of reset at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      reg_we_p1_q <= 1'b0;
      m2r_p1_q    <= 1'b0;
      lt_p1_q     <= '0;
      rd_p1_q     <= '0;
      alu_p1_q    <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      reg_we_p1_q <= reg_we_p1_d;
      m2r_p1_q    <= m2r_p1_d;
      lt_p1_q     <= lt_p1_d;
      rd_p1_q     <= rd_p1_d;
      alu_p1_q    <= alu_p1_d;
    end
  end

  // ---- WB combinational writeback ----
  load_align u_load_align (
    .load_type (lt_p1_q),
    .addr      (alu_p1_q[1:0]),
    .rdata     (mem_rdata),
    .data      (load_data),
    .misalign  (load_mis)
  );

  assign wb_valid     = vld_p1_q;
  assign misalign_err = vld_p1_q & m2r_p1_q & load_mis;
  assign rf_wa        = rd_p1_q;
  assign rf_wd        = m2r_p1_q ? load_data : alu_p1_q;
  // rst gates the write so the instruction caught by a reset never commits.
  // The r0 gate also keeps the bypass from forwarding onto ra==0.
  assign rf_we        = vld_p1_q & reg_we_p1_q & (rd_p1_q != '0) & ~misalign_err & ~rst;

  assign rs_val = (rf_we && (ra1 == rf_wa)) ? rf_wd : rf_rd1;
  assign rt_val = (rf_we && (ra2 == rf_wa)) ? rf_wd : rf_rd2;

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Counting only on non-stalled edges makes a held instruction count once.
  always_comb begin
    cnt_d = cnt_q;
    if (vld_p1_q && !stall && !misalign_err) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_count = cnt_q;
`else
  assign retire_count = '0;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
MEM/WB pipeline register and writeback datapath for the MIPS150 CPU. It sits directly upstream of the register file.
- Captures memory-stage results.
- Aligns and extends load data returned by the synchronous data memory.
- Drives the register-file write port (we/wa/wd).
- Provides a write-to-read bypass. The register file writes on the clock edge and reads asynchronously, so a same-cycle write is not visible to decode without it.

Parameters:
DW, 32, datapath width (fixed at 32; only 32 is supported)
AW, 5, register address width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold the WB pipeline register contents
flush  in  1  load a bubble into the WB pipeline register
m_valid  in  1  memory stage holds a real instruction
m_reg_we  in  1  instruction writes a GPR
m_mem_to_reg  in  1  writeback data comes from memory (load)
m_load_type  in  3  load kind (package constants)
m_rd_addr  in  AW  destination register
m_alu_result  in  DW  ALU result / effective address
mem_rdata  in  DW  data-memory read word; valid in the cycle the load is in WB (one cycle after address)
ra1, ra2  in  AW  decode read addresses (same as the register-file ra1/ra2)
rf_rd1, rf_rd2  in  DW  raw register-file read data
rf_we  out  1  register-file write enable
rf_wa  out  AW  register-file write address
rf_wd  out  DW  register-file write data
rs_val, rt_val  out  DW  bypassed operand values for decode
wb_valid  out  1  WB holds a valid instruction
misalign_err  out  1  misaligned load in WB this cycle
retire_count  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- WB register update priority, per rising edge: rst > flush > stall > load.
  - rst: all WB regs cleared to 0 (valid=0).
  - flush: valid=0; other fields don't-care but held.
  - stall: all fields hold.
  - Otherwise capture all m_* inputs.
- Reset values: wb_valid=0, rf_we=0, rf_wa=0, rf_wd=0, misalign_err=0, retire_count=0.
- rf_wd is combinational from the WB regs and mem_rdata; zero added latency beyond the one pipeline register.
- Load alignment is big-endian, using byte offset a = wb_alu_result[1:0].
  - LB/LBU: byte a = bits [31-8a:24-8a]; sign- or zero-extended.
  - LH/LHU: a[1]=0 selects [31:16], a[1]=1 selects [15:0]; sign- or zero-extended.
  - LW: full word.
  - Reserved load_type codes: full word, no error.
- Misalignment, combinational while the instruction is in WB:
  - Flagged when LH/LHU has a[0]=1, or LW has a!=0, with wb_valid & wb_mem_to_reg.
  - Asserts misalign_err and suppresses the write.
- rf_wd = wb_mem_to_reg ? aligned_load : wb_alu_result.
- rf_we = wb_valid & wb_reg_we & (rf_wa != 0) & ~misalign_err. Writes to r0 are never issued.
- rf_wa = WB rd register.
- Bypass:
  - rs_val = (rf_we & ra1==rf_wa) ? rf_wd : rf_rd1; rt_val is the same with ra2/rf_rd2.
  - ra==0 always yields rf_rd1/rf_rd2 (guaranteed by rf_we gating).
- During stall, rf_we stays asserted for the held instruction. The repeated write of the same value is harmless and required, so the bypass stays consistent.
- Reset mid-operation: the in-flight WB instruction is discarded; no write occurs in the reset cycle or the next one.

Optional Feature:
Macro WB_RETIRE_CNT_EN.
- Defined: 32-bit counter, cleared by rst, wraps at 2^32. It increments on each clock edge where wb_valid & ~stall & ~misalign_err, so each instruction counts once even if stalled.
- Undefined: retire_count tied to 0; no counter logic.

Decomposition:
- Package mips150_wb_pkg:
  - Load-type constants: LT_W=3'd0, LT_B=3'd1, LT_BU=3'd2, LT_H=3'd3, LT_HU=3'd4.
  - DW/AW defaults.
- One combinational sub-module, load_align: inputs load_type, addr[1:0], rdata; outputs data and misalign.

Test Plan:
- Reset: rst=1 for 2 cycles with m_valid=1 -> rf_we=0, wb_valid=0, rf_wd=0 during and one cycle after.
- ALU writeback: m_rd_addr=5, alu=32'h1234_5678, reg_we=1 -> next cycle rf_we=1, rf_wa=5, rf_wd=32'h1234_5678; ra1=5 with rf_rd1=0 -> rs_val=32'h1234_5678.
- Loads with mem_rdata=32'h80FF_7F01:
  - LB a=0 -> FFFF_FF80; LBU a=1 -> 0000_00FF.
  - LH a=2 -> 0000_7F01; LHU a=0 -> 0000_80FF.
  - LW a=0 -> 80FF_7F01.
- Misaligned: LW with alu=32'h0000_0002 -> misalign_err=1, rf_we=0; LH a=3 -> same.
- r0 and flush: rd=0 with reg_we=1 -> rf_we=0, rs_val=rf_rd1 for ra1=0. flush and stall both high -> wb_valid=0 next cycle.
- Stall: hold for 3 cycles -> rf_we/rf_wd constant; with WB_RETIRE_CNT_EN the count rises by exactly 1.
